iob_pwm_deadtime: RTL
=====================

// Module: iob_pwm_deadtime
// PURPOSE
//  Downstream of iob_pwm. Turns the single pwm_output into a complementary
//  high-side/low-side gate pair. Both gates are held low for a programmable
//  dead time around every transition (break-before-make). Adds a sticky
//  fault shutdown and a saturating count of pulses swallowed by dead time.
// PARAMETERS
//  DT_W   8   width of dead_time, in clk cycles
//  CNT_W  16  width of glitch_cnt (saturating)
// PORTS
//  clk         in   1      system clock; all flops on rising edge
//  rst         in   1      asynchronous reset, ACTIVE-LOW (rst==0 resets)
//  pwm_in      in   1      PWM from iob_pwm (same clock domain)
//  en          in   1      1 = drive gates; 0 = both gates off
//  dead_time   in   DT_W   dead interval minus 1, in cycles
//  fault_in    in   1      external fault, level-sensitive, active-high
//  fault_clr   in   1      clears the latched fault
//  out_hi      out  1      high-side gate
//  out_lo      out  1      low-side gate
//  fault       out  1      latched fault flag
//  glitch_cnt  out  CNT_W  number of DEAD restarts, saturating
// BEHAVIOUR
//  Reset (rst==0): state=OFF, pwm_q=0, out_hi=0, out_lo=0, fault=0,
//    glitch_cnt=0, dt counter=0, tgt=0.
//  pwm_q is a one-flop register of pwm_in. The FSM only reads pwm_q.
//  out_hi/out_lo are dedicated flops loaded from next-state; no decode glitches.
//  out_hi and out_lo must never both be 1 in any cycle.
//  States (one-hot): OFF, DEAD, HIGH, LOW, FAULT. Priority each cycle:
//    fault_in > en==0 > normal transition.
//  Any state, fault_in=1 -> FAULT. In FAULT: fault=1, both gates 0.
//  FAULT -> OFF only when fault_clr=1 AND fault_in=0. fault clears on that
//    same edge. If fault_clr and fault_in are both 1, the FSM stays in FAULT.
//  en=0 in any non-FAULT state -> OFF on the next edge; both gates 0.
//  OFF, en=1 -> DEAD, tgt<=pwm_q, cnt<=0, dt_lat<=dead_time.
//  DEAD: both gates 0.
//    pwm_q!=tgt  -> tgt<=pwm_q, cnt<=0, glitch_cnt++ (saturates at all-ones).
//    else if cnt==dt_lat -> HIGH if tgt=1, else LOW.
//    else cnt++.
//    DEAD therefore lasts exactly dt_lat+1 cycles. dead_time=0 still gives a
//    1-cycle gap.
//  dead_time is latched only on entry to DEAD. Changes during DEAD are ignored.
//  HIGH: out_hi=1. If pwm_q==0 -> DEAD, tgt=0, cnt=0, dt_lat<=dead_time.
//  LOW:  out_lo=1. If pwm_q==1 -> DEAD, tgt=1, cnt=0, dt_lat<=dead_time.
//  Latency: pwm_in rises before edge k -> pwm_q=1 after k -> out_lo=0 after
//    k+1 -> out_hi=1 after k+2+dt.
//  Pulses shorter than dt+1 cycles never reach a gate. Each one counts in
//    glitch_cnt.
//  A constant pwm_in (0% or 100% duty) holds LOW or HIGH indefinitely.
//  No counter wraps: cnt is bounded by dt_lat; glitch_cnt saturates.
// TESTING
//  1 rst=0 mid-HIGH -> out_hi=0 asynchronously; after release, state OFF
//    and glitch_cnt=0.
//  2 en=1, dead_time=3, pwm_in 0->1 at edge 10 -> out_lo falls after edge 11;
//    out_hi rises after edge 15; out_hi&out_lo==0 in every cycle.
//  3 dead_time=0, pwm_in toggling every 8 cycles -> exactly 1 all-low cycle
//    per transition; out_hi high 7 of every 8 cycles.
//  4 dead_time=5, in LOW, 2-cycle high pulse on pwm_in -> out_hi stays 0;
//    FSM returns to LOW; glitch_cnt=1.
//  5 in HIGH, fault_in=1 for 1 cycle -> gates 0 next edge, fault=1 stays set.
//    fault_clr=1 while fault_in=1 -> stays in FAULT. fault_clr=1 with
//    fault_in=0 -> OFF, fault=0.
//  6 force glitch_cnt=0xFFFE, apply 3 swallowed pulses -> glitch_cnt=0xFFFF.
//    Change dead_time mid-DEAD -> current interval length unchanged.

Source files
------------

// File: rtl/iob_pwm_deadtime.sv
// rtl/iob_pwm_deadtime.sv - complementary gate driver with break-before-make dead time
// Splits one PWM line into high/low gates, adds sticky fault shutdown and a glitch counter.
module iob_pwm_deadtime #(
    parameter int DT_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pwm_in_i,
    input  logic             en_i,
    input  logic [DT_W-1:0]  dead_time_i,
    input  logic             fault_in_i,
    input  logic             fault_clr_i,
    output logic             out_hi_o,
    output logic             out_lo_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] glitch_cnt_o
);

    typedef enum logic [4:0] {
        S_OFF   = 5'b00001,
        S_DEAD  = 5'b00010,
        S_HIGH  = 5'b00100,
        S_LOW   = 5'b01000,
        S_FAULT = 5'b10000
    } state_e;

    state_e           state_q, state_d;
    logic             pwm_q;
    logic             tgt_q, tgt_d;
    logic [DT_W-1:0]  cnt_q, cnt_d;
    logic [DT_W-1:0]  dt_lat_q, dt_lat_d;
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic             out_hi_q, out_lo_q, fault_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_OFF;
            pwm_q    <= 1'b0;
            tgt_q    <= 1'b0;
            cnt_q    <= '0;
            dt_lat_q <= '0;
            glitch_q <= '0;
            out_hi_q <= 1'b0;
            out_lo_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwm_q    <= pwm_in_i;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            dt_lat_q <= dt_lat_d;
            glitch_q <= glitch_d;
            // Gate flops follow the next state so no decode glitch reaches the pins.
            out_hi_q <= (state_d == S_HIGH);
            out_lo_q <= (state_d == S_LOW);
            fault_q  <= (state_d == S_FAULT);
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        dt_lat_d = dt_lat_q;
        glitch_d = glitch_q;

        if (fault_in_i) begin
            state_d = S_FAULT;
        end else if (state_q == S_FAULT) begin
            if (fault_clr_i) begin
                state_d = S_OFF;
            end
        end else if (!en_i) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d  = S_DEAD;
                    tgt_d    = pwm_q;
                    cnt_d    = '0;
                    dt_lat_d = dead_time_i;
                end
                S_DEAD: begin
                    // A level change restarts the interval but keeps the latched length.
                    if (pwm_q != tgt_q) begin
                        tgt_d = pwm_q;
                        cnt_d = '0;
                        if (glitch_q != {CNT_W{1'b1}}) begin
                            glitch_d = glitch_q + CNT_W'(1);
                        end
                    end else if (cnt_q == dt_lat_q) begin
                        state_d = tgt_q ? S_HIGH : S_LOW;
                    end else begin
                        cnt_d = cnt_q + DT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!pwm_q) begin
                        state_d  = S_DEAD;
                        tgt_d    = 1'b0;
                        cnt_d    = '0;
                        dt_lat_d = dead_time_i;
                    end
                end
                S_LOW: begin
                    if (pwm_q) begin
                        state_d  = S_DEAD;
                        tgt_d    = 1'b1;
                        cnt_d    = '0;
                        dt_lat_d = dead_time_i;
                    end
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end
    end

    assign out_hi_o     = out_hi_q;
    assign out_lo_o     = out_lo_q;
    assign fault_o      = fault_q;
    assign glitch_cnt_o = glitch_q;

endmodule
